reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer downstream of the reservation station.
- Allocates a tag per issued instruction and captures execution results written back by the RS and the LSB.
- Exports a per-entry ready/value view so the RS can forward operands.
- Retires in program order to the register file and store unit, and raises a pipeline flush on branch misprediction at commit.

Parameters:
- DEPTH, 16, number of entries; power of two.
- TAG_W, 4, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; state frozen when low
- issue_valid  in  1  dispatcher presents an instruction
- issue_type  in  2  0=ALU/JAL (writes rd), 1=branch/JALR, 2=store, 3=load
- issue_rd  in  5  destination register
- issue_pc  in  32  instruction PC
- issue_pred_taken  in  1  predictor decision
- issue_ack  out  1  combinational; entry allocated this cycle
- issue_tag  out  TAG_W  combinational; tag of allocated entry (= tail)
- full  out  1  combinational; count == DEPTH
- wb_valid  in  1  result writeback (RS or LSB)
- wb_tag  in  TAG_W  target entry
- wb_value  in  32  result / link value
- wb_taken  in  1  branch outcome (type 1 only)
- wb_target  in  32  resolved branch/JALR target
- rob_valid_vec  out  DEPTH  bit i = entry i busy and done
- rob_value_bus  out  32*DEPTH  entry i value at bits [32i+31:32i]
- commit_valid  out  1  registered 1-cycle pulse; regfile write
- commit_rd  out  5  register written
- commit_value  out  32  value written
- commit_tag  out  TAG_W  retiring tag (regfile clears matching rename)
- store_commit  out  1  registered pulse; LSB may perform store commit_tag
- flush_valid  out  1  registered 1-cycle pulse; mispredict
- flush_pc  out  32  redirect PC

Behaviour:
- Per-entry state: busy, done, type, rd, pc, pred_taken, value, taken, target. State also includes head, tail (TAG_W, wrapping), and count (TAG_W+1).
- Reset: all busy/done=0; head=tail=count=0; all registered outputs 0.
- rdy low: no state change; registered pulses forced 0 next edge.
- Allocate:
  - issue_ack = rdy & issue_valid & !full & !flush_now.
  - On ack: entry[tail] busy=1, done=0, fields latched; tail+1 mod DEPTH.
  - full uses registered count; a same-cycle retire does not free the slot for issue that cycle.
- Writeback:
  - On wb_valid with entry[wb_tag].busy: set done=1, value, taken, target.
  - Writeback to a non-busy entry is ignored.
  - rob_valid_vec/rob_value_bus reflect registered state; a written value is visible one cycle after wb.
- Retire: at most one per cycle, when entry[head].busy & done. The entry is cleared, head+1, and count-1.
  - Type 0/3: commit_valid=1 if rd!=0, else no pulse (entry still retires).
  - Type 1: mispredict = (taken != pred_taken).
    - rd!=0 writes value (JALR/JAL link) as for type 0.
    - On mispredict: flush_pc = taken ? target : pc+4; flush_valid=1.
  - Type 2: store_commit=1, commit_tag=head.
- Flush:
  - flush_now is the combinational mispredict-at-head condition.
  - At the same edge, all entries are cleared and head=tail=count=0.
  - Issue and writeback that cycle are discarded.
- Count: +1 on ack only, -1 on retire only; unchanged when both occur.
- Latency: writeback to earliest commit = 1 cycle; issue to earliest commit = 2 cycles.
- Wrap: pointers roll 15->0. full at count 16, empty at count 0.

Decomposition:
- rob_pkg holds:
  - ROB type encodings (ROB_ALU, ROB_BR, ROB_ST, ROB_LD)
  - DEPTH/TAG_W defaults
  - a NO_TAG sentinel shared with the RS
- No sub-module is needed. The entry array and the pointer logic stay in one module.

Test Plan:
- Issue ALU rd=5 tag0; wb tag0 value 0x1234 -> next cycle rob_valid_vec[0]=1, value bus[31:0]=0x1234; following cycle commit_valid, rd=5, value=0x1234.
- Issue 16 instrs without wb -> full=1, 17th issue_ack=0. Then wb+retire tag0 -> next issue gets tag0 (wrap), count=16.
- Out-of-order wb: tags 0,1,2 issued, wb order 2,1,0 -> commits strictly 0,1,2 on consecutive cycles.
- Branch pc=0x100 pred=0, wb taken=1 target=0x200, with younger tags 1-3 pending -> flush_valid, flush_pc=0x200; count=0, head=tail=0. Same-cycle issue_ack=0.
- Branch pred=1, wb taken=0, pc=0x40 -> flush_pc=0x44. Correct prediction -> no flush, retire only.
- Store tag3 at head done -> store_commit=1, commit_tag=3, commit_valid=0. rd=0 ALU retire -> no commit_valid. rst mid-operation -> all cleared next edge.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: entry type encodings, default geometry, the
// NO_TAG sentinel used by the reservation station, and the per-entry record.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = 4;

  // One bit wider than a real tag so it can never collide with a live entry.
  localparam logic [ROB_TAG_W:0] NO_TAG = {1'b1, {ROB_TAG_W{1'b0}}};

  typedef enum logic [1:0] {
    ROB_ALU = 2'd0,  // ALU / JAL, writes rd
    ROB_BR  = 2'd1,  // branch / JALR
    ROB_ST  = 2'd2,  // store
    ROB_LD  = 2'd3   // load
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        done;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of every reorder-buffer signal except clk/rst.
//   master : dispatcher / writeback / retire consumers (drives issue, wb, rdy)
//   slave  : the reorder buffer itself
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = ROB_TAG_W
);
  logic                  rdy;
  logic                  issue_valid;
  logic [1:0]            issue_type;
  logic [4:0]            issue_rd;
  logic [31:0]           issue_pc;
  logic                  issue_pred_taken;
  logic                  issue_ack;
  logic [TAG_W-1:0]      issue_tag;
  logic                  full;
  logic                  wb_valid;
  logic [TAG_W-1:0]      wb_tag;
  logic [31:0]           wb_value;
  logic                  wb_taken;
  logic [31:0]           wb_target;
  logic [DEPTH-1:0]      rob_valid_vec;
  logic [32*DEPTH-1:0]   rob_value_bus;
  logic                  commit_valid;
  logic [4:0]            commit_rd;
  logic [31:0]           commit_value;
  logic [TAG_W-1:0]      commit_tag;
  logic                  store_commit;
  logic                  flush_valid;
  logic [31:0]           flush_pc;

  modport master (
    output rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    input  issue_ack, issue_tag, full, rob_valid_vec, rob_value_bus,
    input  commit_valid, commit_rd, commit_value, commit_tag, store_commit,
    input  flush_valid, flush_pc
  );

  modport slave (
    input  rdy, issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    output issue_ack, issue_tag, full, rob_valid_vec, rob_value_bus,
    output commit_valid, commit_rd, commit_value, commit_tag, store_commit,
    output flush_valid, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer. Allocates a tag per issued instruction, captures
// writebacks, exposes a per-entry ready/value view for operand forwarding and
// retires in program order, flushing everything on a mispredicted branch at head.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   bus_io : reorder_buffer_if.slave (issue, writeback, forwarding view, commit, flush)
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = ROB_TAG_W
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  bus_io
);

  localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(DEPTH);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             commit_valid_q, commit_valid_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_value_q, commit_value_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic             store_commit_q, store_commit_d;
  logic             flush_valid_q, flush_valid_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  rob_entry_t head_e;
  logic       full, retire, mispredict, flush_now, issue_ack;

  assign head_e     = entries_q[head_q];
  assign full       = (count_q == FullCount);
  assign retire     = bus_io.rdy & head_e.busy & head_e.done;
  assign mispredict = (head_e.typ == ROB_BR) & (head_e.taken != head_e.pred_taken);
  assign flush_now  = retire & mispredict;
  // full uses the registered count: a retire this cycle does not open a slot yet.
  assign issue_ack  = bus_io.rdy & bus_io.issue_valid & ~full & ~flush_now;

  always_comb begin
    entries_d      = entries_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    store_commit_d = 1'b0;
    flush_valid_d  = 1'b0;
    flush_pc_d     = flush_pc_q;

    if (retire) begin
      commit_valid_d = (head_e.typ != ROB_ST) & (head_e.rd != 5'd0);
      store_commit_d = (head_e.typ == ROB_ST);
      commit_rd_d    = head_e.rd;
      commit_value_d = head_e.value;
      commit_tag_d   = head_q;
    end

    if (flush_now) begin
      // Same-cycle issue and writeback are dropped along with every younger entry.
      for (int i = 0; i < int'(DEPTH); i++) entries_d[i] = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      flush_valid_d = 1'b1;
      flush_pc_d    = head_e.taken ? head_e.target : head_e.pc + 32'd4;
    end else begin
      if (bus_io.rdy && bus_io.wb_valid && entries_q[bus_io.wb_tag].busy) begin
        entries_d[bus_io.wb_tag].done   = 1'b1;
        entries_d[bus_io.wb_tag].value  = bus_io.wb_value;
        entries_d[bus_io.wb_tag].taken  = bus_io.wb_taken;
        entries_d[bus_io.wb_tag].target = bus_io.wb_target;
      end
      if (retire) begin
        entries_d[head_q] = '0;
        head_d            = head_q + TAG_W'(1);
      end
      if (issue_ack) begin
        entries_d[tail_q]            = '0;
        entries_d[tail_q].busy       = 1'b1;
        entries_d[tail_q].typ        = rob_type_e'(bus_io.issue_type);
        entries_d[tail_q].rd         = bus_io.issue_rd;
        entries_d[tail_q].pc         = bus_io.issue_pc;
        entries_d[tail_q].pred_taken = bus_io.issue_pred_taken;
        tail_d                       = tail_q + TAG_W'(1);
      end
      unique case ({issue_ack, retire})
        2'b10:   count_d = count_q + (TAG_W + 1)'(1);
        2'b01:   count_d = count_q - (TAG_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      store_commit_q <= 1'b0;
      flush_valid_q  <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      entries_q      <= entries_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      store_commit_q <= store_commit_d;
      flush_valid_q  <= flush_valid_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_comb begin
    bus_io.rob_valid_vec = '0;
    bus_io.rob_value_bus = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus_io.rob_valid_vec[i]          = entries_q[i].busy & entries_q[i].done;
      bus_io.rob_value_bus[32*i +: 32] = entries_q[i].value;
    end
  end

  assign bus_io.issue_ack    = issue_ack;
  assign bus_io.issue_tag    = tail_q;
  assign bus_io.full         = full;
  assign bus_io.commit_valid = commit_valid_q;
  assign bus_io.commit_rd    = commit_rd_q;
  assign bus_io.commit_value = commit_value_q;
  assign bus_io.commit_tag   = commit_tag_q;
  assign bus_io.store_commit = store_commit_q;
  assign bus_io.flush_valid  = flush_valid_q;
  assign bus_io.flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then randomized traffic, all checked
// against a program-order queue model of the buffer.
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(16), .TAG_W(4)) rob_if ();

  reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (rob_if)
  );

  typedef struct {
    int          tag;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic        done;
    logic [31:0] value;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rob_if.rdy              = 1'b1;
    rob_if.issue_valid      = 1'b0;
    rob_if.issue_type       = 2'd0;
    rob_if.issue_rd         = 5'd0;
    rob_if.issue_pc         = 32'd0;
    rob_if.issue_pred_taken = 1'b0;
    rob_if.wb_valid         = 1'b0;
    rob_if.wb_tag           = 4'd0;
    rob_if.wb_value         = 32'd0;
    rob_if.wb_taken         = 1'b0;
    rob_if.wb_target        = 32'd0;
  endtask

  task automatic set_issue(input logic [1:0] typ, input logic [4:0] rd, input logic [31:0] pc,
                           input logic pred);
    rob_if.issue_valid      = 1'b1;
    rob_if.issue_type       = typ;
    rob_if.issue_rd         = rd;
    rob_if.issue_pc         = pc;
    rob_if.issue_pred_taken = pred;
  endtask

  task automatic set_wb(input int tag, input logic [31:0] val, input logic tk,
                        input logic [31:0] tgt);
    rob_if.wb_valid  = 1'b1;
    rob_if.wb_tag    = 4'(tag);
    rob_if.wb_value  = val;
    rob_if.wb_taken  = tk;
    rob_if.wb_target = tgt;
  endtask

  // One clock: check combinational outputs and the forwarding view against the
  // model, advance the model, then check the registered pulses after the edge.
  task automatic cycle();
    logic        exp_full, ret, mis, exp_ack;
    logic [15:0] exp_vec;
    logic        e_cv, e_sc, e_fv;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_fpc;
    int          e_tag;
    ent_t        e;
    #2;
    exp_full = (q.size() == 16);
    ret      = rob_if.rdy && q.size() > 0 && q[0].done;
    mis      = ret && q[0].typ == 2'd1 && q[0].taken != q[0].pred;
    exp_ack  = rob_if.rdy && rob_if.issue_valid && !exp_full && !mis;
    check_eq("full", 64'(rob_if.full), 64'(exp_full));
    check_eq("issue_ack", 64'(rob_if.issue_ack), 64'(exp_ack));
    check_eq("issue_tag", 64'(rob_if.issue_tag), 64'(next_tag));
    exp_vec = '0;
    foreach (q[i]) begin
      if (q[i].done) begin
        exp_vec[q[i].tag] = 1'b1;
        check_eq("rob_value", 64'(rob_if.rob_value_bus[q[i].tag*32 +: 32]), 64'(q[i].value));
      end
    end
    check_eq("rob_valid_vec", 64'(rob_if.rob_valid_vec), 64'(exp_vec));

    e_cv = 1'b0; e_sc = 1'b0; e_fv = 1'b0;
    e_rd = '0; e_val = '0; e_fpc = '0; e_tag = 0;
    if (ret) begin
      e     = q[0];
      e_cv  = e.typ != 2'd2 && e.rd != 5'd0;
      e_sc  = e.typ == 2'd2;
      e_fv  = mis;
      e_fpc = e.taken ? e.target : e.pc + 32'd4;
      e_rd  = e.rd;
      e_val = e.value;
      e_tag = e.tag;
    end
    if (rob_if.rdy) begin
      if (mis) begin
        q.delete();
        next_tag = 0;
      end else begin
        if (rob_if.wb_valid) begin
          foreach (q[i]) begin
            if (q[i].tag == int'(rob_if.wb_tag)) begin
              q[i].done   = 1'b1;
              q[i].value  = rob_if.wb_value;
              q[i].taken  = rob_if.wb_taken;
              q[i].target = rob_if.wb_target;
            end
          end
        end
        if (ret) void'(q.pop_front());
        if (exp_ack) begin
          e = '{tag: next_tag, typ: rob_if.issue_type, rd: rob_if.issue_rd,
                pc: rob_if.issue_pc, pred: rob_if.issue_pred_taken, done: 1'b0,
                value: 32'd0, taken: 1'b0, target: 32'd0};
          q.push_back(e);
          next_tag = (next_tag + 1) % 16;
        end
      end
    end

    @(posedge clk);
    #1;
    check_eq("commit_valid", 64'(rob_if.commit_valid), 64'(e_cv));
    check_eq("store_commit", 64'(rob_if.store_commit), 64'(e_sc));
    check_eq("flush_valid", 64'(rob_if.flush_valid), 64'(e_fv));
    if (e_cv) begin
      check_eq("commit_rd", 64'(rob_if.commit_rd), 64'(e_rd));
      check_eq("commit_value", 64'(rob_if.commit_value), 64'(e_val));
      check_eq("commit_tag", 64'(rob_if.commit_tag), 64'(e_tag));
    end
    if (e_sc) check_eq("store_tag", 64'(rob_if.commit_tag), 64'(e_tag));
    if (e_fv) check_eq("flush_pc", 64'(rob_if.flush_pc), 64'(e_fpc));
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    next_tag = 0;
    check_eq("rst_commit_valid", 64'(rob_if.commit_valid), 64'd0);
    check_eq("rst_store_commit", 64'(rob_if.store_commit), 64'd0);
    check_eq("rst_flush_valid", 64'(rob_if.flush_valid), 64'd0);
    check_eq("rst_flush_pc", 64'(rob_if.flush_pc), 64'd0);
    check_eq("rst_full", 64'(rob_if.full), 64'd0);
    check_eq("rst_valid_vec", 64'(rob_if.rob_valid_vec), 64'd0);
    check_eq("rst_issue_tag", 64'(rob_if.issue_tag), 64'd0);
  endtask

  initial begin
    set_idle();
    do_reset();

    // Basic issue -> writeback -> commit.
    set_idle(); set_issue(2'd0, 5'd5, 32'h0, 1'b0); cycle();
    set_idle(); set_wb(0, 32'h1234, 1'b0, 32'h0); cycle();
    set_idle(); cycle();
    set_idle(); cycle();

    // Fill to 16, 17th refused, retire does not free the slot the same cycle, then wrap.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_idle(); set_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0); cycle();
    end
    set_idle(); set_issue(2'd0, 5'd9, 32'h80, 1'b0); set_wb(0, 32'hAA, 1'b0, 32'h0); cycle();
    set_idle(); set_issue(2'd0, 5'd9, 32'h80, 1'b0); cycle();
    set_idle(); set_issue(2'd0, 5'd9, 32'h80, 1'b0); cycle();
    set_idle(); set_issue(2'd0, 5'd9, 32'h84, 1'b0); cycle();

    // Out-of-order writeback, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_issue(2'd0, 5'(i + 10), 32'(i * 4), 1'b0); cycle();
    end
    for (int i = 2; i >= 0; i--) begin
      set_idle(); set_wb(i, 32'(100 + i), 1'b0, 32'h0); cycle();
    end
    for (int i = 0; i < 4; i++) begin set_idle(); cycle(); end

    // Mispredict taken with younger work pending; issue during flush is refused.
    do_reset();
    set_idle(); set_issue(2'd1, 5'd0, 32'h100, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_issue(2'd0, 5'd3, 32'(32'h104 + i * 4), 1'b0); cycle();
    end
    set_idle(); set_wb(0, 32'h0, 1'b1, 32'h200); cycle();
    set_idle(); set_issue(2'd0, 5'd4, 32'h300, 1'b0); set_wb(1, 32'h7, 1'b0, 32'h0); cycle();
    set_idle(); cycle();

    // Mispredict not-taken, then a correctly predicted JALR writing its link.
    set_idle(); set_issue(2'd1, 5'd0, 32'h40, 1'b1); cycle();
    set_idle(); set_wb(0, 32'h0, 1'b0, 32'h999); cycle();
    set_idle(); cycle();
    set_idle(); set_issue(2'd1, 5'd1, 32'h50, 1'b1); cycle();
    set_idle(); set_wb(0, 32'h54, 1'b1, 32'h60); cycle();
    set_idle(); cycle();
    set_idle(); cycle();

    // rd=0 ALU retires silently; store at tag3 commits to the LSB.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_issue((i == 3) ? 2'd2 : 2'd0, 5'd0, 32'(i * 4), 1'b0); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      set_idle(); set_wb(i, 32'(i), 1'b0, 32'h0); cycle();
    end
    for (int i = 0; i < 4; i++) begin set_idle(); cycle(); end

    // rdy low freezes state.
    set_idle(); set_issue(2'd0, 5'd7, 32'h10, 1'b0); cycle();
    set_idle(); set_wb(0, 32'h55, 1'b0, 32'h0); cycle();
    set_idle(); rob_if.rdy = 1'b0; set_issue(2'd0, 5'd8, 32'h14, 1'b0); cycle();
    set_idle(); cycle();

    // Randomized traffic with occasional mid-run resets and stalls.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      set_idle();
      rob_if.rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 7) begin
        logic pred;
        pred = 1'($urandom);
        set_issue(2'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  pred);
      end
      if ($urandom_range(0, 9) < 4) begin
        int          t;
        logic        tk;
        t  = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
             q[$urandom_range(0, q.size() - 1)].tag : int'($urandom_range(0, 15));
        tk = 1'($urandom);
        foreach (q[i]) if (q[i].tag == t && $urandom_range(0, 4) != 0) tk = q[i].pred;
        set_wb(t, $urandom, tk, $urandom);
      end
      cycle();
    end

    // Reset with entries in flight must clear everything.
    for (int i = 0; i < 5; i++) begin
      set_idle(); set_issue(2'd0, 5'd2, 32'(i * 4), 1'b0); set_wb(0, 32'h1, 1'b0, 32'h0); cycle();
    end
    do_reset();
    set_idle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
